line_burst_adapter: RTL and testbench
=====================================

Name: line_burst_adapter

Overview:
- Sits directly downstream of the I/D-cache arbiter, between the arbiter's 256-bit line port and the 64-bit burst physical-memory port.
- Converts one line read into a 4-beat burst read and assembles the line.
- Converts one line write into a 4-beat burst write.
- Returns a single-cycle line response to the arbiter after the burst completes.

Parameters:
- BEAT_W, 64, width of one memory beat.
- BEATS, 4, beats per line; LINE_W = BEAT_W*BEATS = 256.
- OFFSET_W, 5, line-offset bits zeroed in the outgoing burst address.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- line_read  input  1  line read request; held until line_resp
- line_write  input  1  line write request; held until line_resp
- line_addr  input  32  request address
- line_wdata  input  256  line to write
- line_rdata  output  256  assembled read line
- line_resp  output  1  one-cycle completion pulse
- mem_read  output  1  burst read request
- mem_write  output  1  burst write request
- mem_addr  output  32  line-aligned burst address
- mem_wdata  output  64  current write beat
- mem_rdata  input  64  current read beat
- mem_resp  input  1  per-beat acknowledge

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - State goes to IDLE; beat counter and all data/address registers clear to 0.
  - All outputs are 0 in the cycle after rst is sampled.
- States:
  - IDLE, READ_BURST, READ_DONE, WRITE_BURST, WRITE_DONE.
- IDLE:
  - Samples requests. If line_write is high, latch {line_addr[31:5],5'b0} and line_wdata, clear the counter, go to WRITE_BURST.
  - Else if line_read is high, latch the aligned address, clear the counter, go to READ_BURST.
  - Both requests high is an illegal input; write wins deterministically.
  - mem_read and mem_write are 0 in IDLE; mem_resp is ignored.
- READ_BURST:
  - mem_read=1; mem_addr = latched aligned address, constant for the whole burst.
  - On each cycle with mem_resp=1, write mem_rdata into line beat slot cnt (beat k -> bits [64k+63:64k]) and increment cnt.
  - When mem_resp=1 and cnt==BEATS-1, go to READ_DONE. mem_read stays 1 through the cycle that accepts the last beat.
  - mem_resp=0 stalls: no capture, no increment.
- READ_DONE:
  - line_resp=1 for exactly one cycle; line_rdata holds the complete line; next state is IDLE.
- WRITE_BURST:
  - mem_write=1; mem_wdata = latched line beat cnt (beat 0 = bits [63:0]).
  - Advance on mem_resp exactly as in READ_BURST; go to WRITE_DONE after beat BEATS-1 is accepted.
- WRITE_DONE:
  - line_resp=1 for one cycle; next state is IDLE.
- line_rdata:
  - Registered output; holds its value until the next read burst overwrites it beat by beat.
  - Not valid for consumption except when line_resp=1 after a read.
- Minimum latency: request seen in IDLE at cycle 0 -> beats at cycles 1..4 (mem_resp every cycle) -> line_resp at cycle 5.
- Counter:
  - log2(BEATS) bits; reaches BEATS-1 only at the last beat.
  - Never wraps within a burst; cleared on entry to each burst.
- Request-input sampling:
  - line_addr, line_wdata and request changes during a burst are ignored; values are latched at IDLE.
  - A request still high in the cycle after line_resp starts a new transaction; the upstream arbiter drops its request that cycle.
- mem_resp in IDLE/DONE states: ignored, with no state or data effect.
- Reset mid-burst:
  - Burst is abandoned; next cycle is IDLE with mem_read/mem_write=0.
  - Partial line is discarded; line_rdata=0; no line_resp is generated.

Test Plan:
- Read, no stalls: line_read=1, line_addr=0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  - mem_addr=0x0000_1220 for the whole burst.
  - line_resp at cycle 5 for one cycle.
  - line_rdata={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write with stalls: line_write=1, addr 0x8000_00E0, line_wdata={D3,D2,D1,D0}, mem_resp high only every third cycle.
  - mem_wdata steps D0->D1->D2->D3, advancing only after each mem_resp.
  - mem_write is high continuously until the 4th beat is accepted.
  - One line_resp after that.
- Back-to-back: a write then a read, each request held until line_resp.
  - Each burst is exactly 4 beats, with exactly one line_resp per transaction.
  - The read data is unaffected by the prior write data.
- Both requests asserted: line_read=line_write=1 in IDLE.
  - A write burst is performed, mem_read stays 0, one line_resp.
- Reset mid-read: assert rst after 2 of 4 beats.
  - Next cycle: mem_read=0, line_resp=0, line_rdata=0.
  - A new read afterwards completes normally with correct data.
- Spurious mem_resp=1 while in IDLE.
  - No state change, no line_resp, line_rdata unchanged.

Source files
------------

// File: rtl/line_burst_adapter.sv
// line_burst_adapter
//   Bridges the cache arbiter's 256-bit line port to a 64-bit burst memory
//   port. A line read becomes a BEATS-beat burst read whose beats are
//   assembled into line_rdata. A line write becomes a BEATS-beat burst write.
//   After the last beat is accepted, line_resp pulses for one cycle.
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   line_read     line read request, held until line_resp
//   line_write    line write request, held until line_resp (wins over read)
//   line_addr     request address (offset bits are dropped)
//   line_wdata    line to write, latched when the request is accepted
//   line_rdata    assembled read line, valid while line_resp follows a read
//   line_resp     one-cycle completion pulse
//   mem_read      burst read request
//   mem_write     burst write request
//   mem_addr      line-aligned burst address
//   mem_wdata     current write beat
//   mem_rdata     current read beat
//   mem_resp      per-beat acknowledge
module line_burst_adapter #(
  parameter int BEAT_W   = 64,
  parameter int BEATS    = 4,
  parameter int OFFSET_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      line_read,
  input  logic                      line_write,
  input  logic [31:0]               line_addr,
  input  logic [BEAT_W*BEATS-1:0]   line_wdata,
  output logic [BEAT_W*BEATS-1:0]   line_rdata,
  output logic                      line_resp,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [31:0]               mem_addr,
  output logic [BEAT_W-1:0]         mem_wdata,
  input  logic [BEAT_W-1:0]         mem_rdata,
  input  logic                      mem_resp
);

  localparam int LINE_W = BEAT_W * BEATS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BEATS - 1);
  localparam logic [31:0]      OFFSET_MASK = (32'd1 << OFFSET_W) - 32'd1;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] READ_BURST  = 3'd1;
  localparam logic [2:0] READ_DONE   = 3'd2;
  localparam logic [2:0] WRITE_BURST = 3'd3;
  localparam logic [2:0] WRITE_DONE  = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [31:0]       addr_nxt;
  logic [LINE_W-1:0] wbuf;
  logic [LINE_W-1:0] wbuf_nxt;
  logic [LINE_W-1:0] rdata_nxt;
  logic [BEAT_W-1:0] beat_sel;

  // Next-state, counter, address latch and line assembly.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = mem_addr;
    wbuf_nxt  = wbuf;
    rdata_nxt = line_rdata;
    case (state)
      IDLE: begin
        if (line_write) begin
          addr_nxt  = line_addr & ~OFFSET_MASK;
          wbuf_nxt  = line_wdata;
          cnt_nxt   = '0;
          state_nxt = WRITE_BURST;
        end else if (line_read) begin
          addr_nxt  = line_addr & ~OFFSET_MASK;
          cnt_nxt   = '0;
          state_nxt = READ_BURST;
        end else begin
          state_nxt = IDLE;
        end
      end
      READ_BURST: begin
        if (mem_resp) begin
          for (int k = 0; k < BEATS; k++) begin
            rdata_nxt[k*BEAT_W +: BEAT_W] = (cnt == CNT_W'(k)) ? mem_rdata
                                                                : line_rdata[k*BEAT_W +: BEAT_W];
          end
          // The counter holds at the last beat so it never wraps inside a burst.
          if (cnt == LAST_BEAT) begin
            state_nxt = READ_DONE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          state_nxt = READ_BURST;
        end
      end
      WRITE_BURST: begin
        if (mem_resp) begin
          if (cnt == LAST_BEAT) begin
            state_nxt = WRITE_DONE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          state_nxt = WRITE_BURST;
        end
      end
      READ_DONE:  state_nxt = IDLE;
      WRITE_DONE: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Write beat presented in the next cycle, chosen from the next counter value.
  always_comb begin
    beat_sel = '0;
    for (int k = 0; k < BEATS; k++) begin
      beat_sel = (cnt_nxt == CNT_W'(k)) ? wbuf_nxt[k*BEAT_W +: BEAT_W] : beat_sel;
    end
  end

  // State, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wbuf       <= '0;
      line_rdata <= '0;
      line_resp  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      wbuf       <= wbuf_nxt;
      line_rdata <= rdata_nxt;
      line_resp  <= (state_nxt == READ_DONE) || (state_nxt == WRITE_DONE);
      mem_read   <= (state_nxt == READ_BURST);
      mem_write  <= (state_nxt == WRITE_BURST);
      mem_addr   <= addr_nxt;
      mem_wdata  <= (state_nxt == WRITE_BURST) ? beat_sel : '0;
    end
  end

endmodule

// File: tb/tb_line_burst_adapter.sv
module tb_line_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_addr;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: line_rdata is the last completed read line (0 after reset).
  logic [255:0] exp_rdata;
  logic [63:0]  wbeat [4];
  logic [63:0]  rbeat [4];
  int           last_resp_cyc;

  line_burst_adapter dut (
    .clk(clk), .rst(rst),
    .line_read(line_read), .line_write(line_write),
    .line_addr(line_addr), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic rand_beats();
    for (int i = 0; i < 4; i++) begin
      wbeat[i] = {$urandom(), $urandom()};
      rbeat[i] = {$urandom(), $urandom()};
    end
  endtask

  // Drives one line transaction and acts as the burst memory.
  // stall_mode: 0 = ack every cycle, 1 = ack every third cycle, 2 = random.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input int stall_mode, input string tag);
    logic [31:0] exp_addr;
    bit          exp_wr;
    bit          resp;
    bit          resp_seen;
    int          beats;
    int          cyc;
    exp_addr   = addr & 32'hFFFF_FFE0;
    exp_wr     = wr;
    line_read  = rd;
    line_write = wr;
    line_addr  = addr;
    line_wdata = {wbeat[3], wbeat[2], wbeat[1], wbeat[0]};
    mem_resp   = 1'b0;
    beats      = 0;
    cyc        = 0;
    resp_seen  = 1'b0;
    while (!resp_seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (line_resp === 1'b1) begin
        resp_seen     = 1'b1;
        last_resp_cyc = cyc;
        n_cmp++;
        if (beats !== 4) begin
          n_err++;
          $display("FAIL %s beat_count: got %0d want 4", tag, beats);
        end
        n_cmp++;
        if ({mem_read, mem_write} !== 2'b00) begin
          n_err++;
          $display("FAIL %s req_at_resp: rd/wr=%b want 00", tag, {mem_read, mem_write});
        end
        if (!exp_wr) exp_rdata = {rbeat[3], rbeat[2], rbeat[1], rbeat[0]};
        n_cmp++;
        if (line_rdata !== exp_rdata) begin
          n_err++;
          $display("FAIL %s line_rdata: got %h want %h", tag, line_rdata, exp_rdata);
        end
        line_read  = 1'b0;
        line_write = 1'b0;
        mem_resp   = 1'b0;
      end else begin
        n_cmp++;
        if (mem_read !== ~exp_wr || mem_write !== exp_wr) begin
          n_err++;
          $display("FAIL %s mem_req cyc%0d: rd=%b wr=%b want rd=%b wr=%b",
                   tag, cyc, mem_read, mem_write, ~exp_wr, exp_wr);
        end
        n_cmp++;
        if (mem_addr !== exp_addr) begin
          n_err++;
          $display("FAIL %s mem_addr: got %h want %h", tag, mem_addr, exp_addr);
        end
        if (exp_wr && beats < 4) begin
          n_cmp++;
          if (mem_wdata !== wbeat[beats]) begin
            n_err++;
            $display("FAIL %s mem_wdata beat%0d: got %h want %h", tag, beats, mem_wdata, wbeat[beats]);
          end
        end
        case (stall_mode)
          0:       resp = 1'b1;
          1:       resp = (cyc % 3 == 0);
          default: resp = ($urandom_range(0, 1) == 1);
        endcase
        if (beats >= 4) resp = 1'b0;
        mem_resp  = resp;
        mem_rdata = resp ? rbeat[beats] : {$urandom(), $urandom()};
        if (resp) beats++;
      end
    end
    if (!resp_seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: no line_resp after %0d cycles", tag, cyc);
    end
    @(negedge clk);
    n_cmp++;
    if ({line_resp, mem_read, mem_write} !== 3'b000) begin
      n_err++;
      $display("FAIL %s after_resp: resp/rd/wr=%b want 000", tag, {line_resp, mem_read, mem_write});
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    line_read  = 1'b0;
    line_write = 1'b0;
    line_addr  = 32'd0;
    line_wdata = '0;
    mem_rdata  = 64'd0;
    mem_resp   = 1'b0;
    exp_rdata  = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({line_resp, mem_read, mem_write} !== 3'b000 || mem_addr !== 32'd0 ||
        mem_wdata !== 64'd0 || line_rdata !== 256'd0) begin
      n_err++;
      $display("FAIL reset_outputs: resp/rd/wr=%b addr=%h wdata=%h rdata=%h want all 0",
               {line_resp, mem_read, mem_write}, mem_addr, mem_wdata, line_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_basic();
    rbeat[0] = 64'h1111_1111_1111_1111;
    rbeat[1] = 64'h2222_2222_2222_2222;
    rbeat[2] = 64'h3333_3333_3333_3333;
    rbeat[3] = 64'h4444_4444_4444_4444;
    do_txn(1'b1, 1'b0, 32'h0000_1234, 0, "read_basic");
    n_cmp++;
    if (last_resp_cyc !== 5) begin
      n_err++;
      $display("FAIL read_latency: line_resp at cycle %0d want 5", last_resp_cyc);
    end
  endtask

  task automatic test_write_stall();
    wbeat[0] = 64'hD0D0_D0D0_0000_0000;
    wbeat[1] = 64'hD1D1_D1D1_1111_1111;
    wbeat[2] = 64'hD2D2_D2D2_2222_2222;
    wbeat[3] = 64'hD3D3_D3D3_3333_3333;
    do_txn(1'b0, 1'b1, 32'h8000_00E0, 1, "write_stall");
    n_cmp++;
    if (last_resp_cyc !== 13) begin
      n_err++;
      $display("FAIL write_stall_latency: line_resp at cycle %0d want 13", last_resp_cyc);
    end
  endtask

  task automatic test_back_to_back();
    rand_beats();
    do_txn(1'b0, 1'b1, {$urandom()}, 2, "b2b_write");
    rand_beats();
    do_txn(1'b1, 1'b0, {$urandom()}, 2, "b2b_read");
  endtask

  task automatic test_both_requests();
    rand_beats();
    do_txn(1'b1, 1'b1, 32'h0040_0A5F, 0, "both_req");
  endtask

  task automatic test_reset_mid_read();
    rand_beats();
    line_read = 1'b1;
    line_addr = 32'h0000_7777;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      mem_resp  = 1'b1;
      mem_rdata = rbeat[c-1];
    end
    @(negedge clk);
    mem_resp = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    line_read = 1'b0;
    exp_rdata = '0;
    n_cmp++;
    if ({mem_read, mem_write, line_resp} !== 3'b000 || line_rdata !== 256'd0) begin
      n_err++;
      $display("FAIL reset_mid_read: rd/wr/resp=%b rdata=%h want 000 and 0",
               {mem_read, mem_write, line_resp}, line_rdata);
    end
    @(negedge clk);
    rand_beats();
    do_txn(1'b1, 1'b0, 32'h0000_7777, 0, "read_after_reset");
  endtask

  task automatic test_spurious_resp();
    line_read  = 1'b0;
    line_write = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mem_resp  = 1'b1;
      mem_rdata = {$urandom(), $urandom()};
      @(negedge clk);
      n_cmp++;
      if ({line_resp, mem_read, mem_write} !== 3'b000 || line_rdata !== exp_rdata) begin
        n_err++;
        $display("FAIL spurious_resp cyc%0d: resp/rd/wr=%b rdata=%h want 000 rdata=%h",
                 c, {line_resp, mem_read, mem_write}, line_rdata, exp_rdata);
      end
    end
    mem_resp = 1'b0;
    rand_beats();
    do_txn(1'b1, 1'b0, 32'hABCD_0010, 0, "read_after_spurious");
  endtask

  task automatic test_random();
    bit wr;
    for (int t = 0; t < 20; t++) begin
      rand_beats();
      wr = ($urandom_range(0, 1) == 1);
      do_txn(~wr, wr, {$urandom()}, 2, wr ? "rand_write" : "rand_read");
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_stall();
    test_back_to_back();
    test_both_requests();
    test_reset_mid_read();
    test_spurious_resp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
